// File: rtl/line_raster_pkg.sv
// Shared types for the line rasteriser: pixel/segment structs, FSM states, widths.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package line_raster_pkg;

    localparam int COORD_W = 16;
    localparam int ERR_W   = COORD_W + 2;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } Point2D;

    typedef struct packed {
        Point2D s;
        Point2D p;
    } Line2D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DRAW
    } raster_state_t;

    typedef logic signed [ERR_W-1:0] err_t;

    // |a-b| computed at the wider error width so the difference cannot overflow
    function automatic err_t abs_diff(input logic signed [COORD_W-1:0] a,
                                      input logic signed [COORD_W-1:0] b);
        err_t d;
        d = err_t'(a) - err_t'(b);
        return (d < 0) ? -d : d;
    endfunction

endpackage

// File: rtl/line_raster_step.sv
// One Bresenham step: next point and next error term from the current ones.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit the result.
module raster_step
    import line_raster_pkg::*;
#(
    parameter int COORD_W = line_raster_pkg::COORD_W
) (
    input  Point2D                    cur,
    input  logic signed [COORD_W+1:0] err,
    input  logic signed [COORD_W+1:0] dx,
    input  logic signed [COORD_W+1:0] dy,
    input  logic signed [1:0]         sx,
    input  logic signed [1:0]         sy,
    output Point2D                    nxt_cur,
    output logic signed [COORD_W+1:0] nxt_err
);

    logic signed [COORD_W+1:0] e2;

    // Both axis decisions look at the pre-step error; their error updates add up
    always_comb begin
        e2      = {err[COORD_W:0], 1'b0};
        nxt_cur = cur;
        nxt_err = err;
        if (e2 >= dy) begin
            nxt_err   = nxt_err + dy;
            nxt_cur.x = cur.x + COORD_W'(sx);
        end
        if (e2 <= dx) begin
            nxt_err   = nxt_err + dx;
            nxt_cur.y = cur.y + COORD_W'(sy);
        end
    end

endmodule

// File: rtl/line_raster.sv
// Walks an accepted clipped segment s->p with a Bresenham stepper, one pixel per cycle.
// Latency: input handshake N -> setup N+1 -> first pixel valid N+2.
// Backpressure: pix_ready low freezes pixel and all state; in_ready high only when idle.
module line_raster
    import line_raster_pkg::*;
#(
    parameter int COORD_W = line_raster_pkg::COORD_W
) (
    input  logic   clk,
    input  logic   rst,
    input  Line2D  line_in,
    input  logic   accept_in,
    input  logic   in_valid,
    output logic   in_ready,
    output Point2D pix_out,
    output logic   pix_valid,
    input  logic   pix_ready,
    output logic   pix_last,
    output logic   busy
);

    localparam int EW = COORD_W + 2;

    raster_state_t          state;
    Point2D                 s_pt;
    Point2D                 p_pt;
    logic signed [EW-1:0]   dx;
    logic signed [EW-1:0]   dy;
    logic signed [EW-1:0]   err;
    logic signed [1:0]      sx;
    logic signed [1:0]      sy;

    logic signed [EW-1:0]   su_dx;
    logic signed [EW-1:0]   su_dy;
    logic signed [1:0]      su_sx;
    logic signed [1:0]      su_sy;
    Point2D                 nxt_cur;
    logic signed [EW-1:0]   nxt_err;

    // Stepper terms derived from the registered endpoints, committed in SETUP
    always_comb begin
        su_dx = abs_diff(p_pt.x, s_pt.x);
        su_dy = -abs_diff(p_pt.y, s_pt.y);
        su_sx = (p_pt.x > s_pt.x) ? 2'sb01 : 2'sb11;
        su_sy = (p_pt.y > s_pt.y) ? 2'sb01 : 2'sb11;
    end

    raster_step #(.COORD_W(COORD_W)) u_step (
        .cur     (pix_out),
        .err     (err),
        .dx      (dx),
        .dy      (dy),
        .sx      (sx),
        .sy      (sy),
        .nxt_cur (nxt_cur),
        .nxt_err (nxt_err)
    );

    // Control FSM; pix_out doubles as the current-point register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            s_pt      <= '0;
            p_pt      <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            sx        <= '0;
            sy        <= '0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // rejected lines are simply consumed here
                    if (in_valid && accept_in) begin
                        s_pt     <= line_in.s;
                        p_pt     <= line_in.p;
                        state    <= ST_SETUP;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    dx        <= su_dx;
                    dy        <= su_dy;
                    sx        <= su_sx;
                    sy        <= su_sy;
                    err       <= su_dx + su_dy;
                    pix_out   <= s_pt;
                    pix_valid <= 1'b1;
                    pix_last  <= (s_pt == p_pt);
                    state     <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (pix_ready) begin
                        if (pix_last) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            pix_out  <= nxt_cur;
                            err      <= nxt_err;
                            pix_last <= (nxt_cur == p_pt);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
